// File: rtl/io_port.sv
// -----------------------------------------------------------------------------
// io_port
// Memory-mapped I/O port that sits on a CPU bus and exposes a 3-word window.
//
//   BASE+0  write : push DATA_IN into the TX FIFO
//   BASE+0  read  : return the RX holding word and clear rx_full
//   BASE+1  read  : status word {8'h00, tx_count[3:0], tx_overflow,
//                                rx_full, tx_full, tx_empty}
//   BASE+2  write : control (bit0 flush TX FIFO, bit1 clear tx_overflow)
//
// Ports
//   CLK        in   1   clock, rising edge
//   RST        in   1   asynchronous active-low reset
//   ADDR       in  16   CPU address
//   DATA_IN    in  16   CPU write data
//   WR / RD    in   1   CPU write / read strobes, sampled on the clock edge
//   DATA_OUT   out 16   registered read data; zero unless answering a read
//   OUT_DATA   out 16   TX FIFO head word (zero while OUT_VALID=0)
//   OUT_VALID  out  1   TX FIFO non-empty
//   OUT_READY  in   1   consumer takes OUT_DATA on this edge
//   IN_DATA    in  16   external input word
//   IN_VALID   in   1   IN_DATA valid
//   IN_READY   out  1   RX holding register empty
// -----------------------------------------------------------------------------
module io_port #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_IN,
  input  logic        WR,
  input  logic        RD,
  output logic [15:0] DATA_OUT,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  input  logic [15:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [15:0] L_ADDR_DATA = BASE_ADDR;
  localparam logic [15:0] L_ADDR_STAT = BASE_ADDR + 16'd1;
  localparam logic [15:0] L_ADDR_CTL  = BASE_ADDR + 16'd2;

  localparam logic [CW-1:0] L_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] L_CNT_ONE = CW'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  // State
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_tx_ovf;
  logic          r_rx_full;
  logic [15:0]   r_rx_data;
  logic [15:0]   r_data_out;

  // Decode and handshake terms
  logic          w_sel_data;
  logic          w_sel_stat;
  logic          w_sel_ctl;
  logic          w_push_req;
  logic          w_ctl_wr;
  logic          w_rd_rx;
  logic          w_rd_stat;
  logic          w_flush;
  logic          w_ovf_clr;
  logic          w_tx_empty;
  logic          w_tx_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_capture;
  logic [3:0]    w_cnt4;
  logic [15:0]   w_status;

  // Next-state values
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_tx_ovf_nxt;
  logic          w_rx_full_nxt;
  logic [15:0]   w_rx_data_nxt;
  logic [15:0]   w_data_out_nxt;

  assign w_sel_data = (ADDR == L_ADDR_DATA);
  assign w_sel_stat = (ADDR == L_ADDR_STAT);
  assign w_sel_ctl  = (ADDR == L_ADDR_CTL);

  // A write on the same edge as a read wins; the read is dropped entirely.
  assign w_push_req = WR & w_sel_data;
  assign w_ctl_wr   = WR & w_sel_ctl;
  assign w_rd_rx    = RD & ~WR & w_sel_data;
  assign w_rd_stat  = RD & ~WR & w_sel_stat;

  assign w_flush    = w_ctl_wr & DATA_IN[0];
  assign w_ovf_clr  = w_ctl_wr & DATA_IN[1];

  assign w_tx_empty = (r_count == {CW{1'b0}});
  assign w_tx_full  = (r_count == L_DEPTH);
  assign w_pop      = ~w_tx_empty & OUT_READY;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push     = w_push_req & (~w_tx_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;
  assign w_capture  = IN_VALID & ~r_rx_full;

  assign w_cnt4     = 4'(r_count);
  // Built from current registers, so a status read shows pre-edge values.
  assign w_status   = {8'h00, w_cnt4, r_tx_ovf, r_rx_full, w_tx_full, w_tx_empty};

  assign OUT_VALID  = ~w_tx_empty;
  assign OUT_DATA   = OUT_VALID ? r_mem[r_rd_ptr] : 16'h0000;
  assign IN_READY   = ~r_rx_full;
  assign DATA_OUT   = r_data_out;

  // TX FIFO pointer and count next-state; flush overrides push and pop.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_flush) begin
      w_wr_ptr_nxt = {AW{1'b0}};
      w_rd_ptr_nxt = {AW{1'b0}};
      w_count_nxt  = {CW{1'b0}};
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + L_PTR_ONE;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + L_PTR_ONE;
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + L_CNT_ONE;
        2'b01:   w_count_nxt = r_count - L_CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Sticky overflow, RX holding register and read-data next-state.
  always_comb begin
    w_tx_ovf_nxt   = r_tx_ovf;
    w_rx_full_nxt  = r_rx_full;
    w_rx_data_nxt  = r_rx_data;
    w_data_out_nxt = 16'h0000;

    if (w_ovf_clr) begin
      w_tx_ovf_nxt = 1'b0;
    end else if (w_drop) begin
      w_tx_ovf_nxt = 1'b1;
    end else begin
      w_tx_ovf_nxt = r_tx_ovf;
    end

    // Capture only happens while empty, and a read of an empty register has
    // no side effect, so capture taking priority is always correct.
    if (w_capture) begin
      w_rx_full_nxt = 1'b1;
      w_rx_data_nxt = IN_DATA;
    end else if (w_rd_rx) begin
      w_rx_full_nxt = 1'b0;
      w_rx_data_nxt = r_rx_data;
    end else begin
      w_rx_full_nxt = r_rx_full;
      w_rx_data_nxt = r_rx_data;
    end

    // DATA_OUT is zero on every edge that is not an accepted read.
    if (w_rd_rx) begin
      w_data_out_nxt = r_rx_data;
    end else if (w_rd_stat) begin
      w_data_out_nxt = w_status;
    end else begin
      w_data_out_nxt = 16'h0000;
    end
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_tx_ovf   <= 1'b0;
      r_rx_full  <= 1'b0;
      r_rx_data  <= 16'h0000;
      r_data_out <= 16'h0000;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_tx_ovf   <= w_tx_ovf_nxt;
      r_rx_full  <= w_rx_full_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

  // FIFO storage; contents are never observed while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (RST && w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_io_port.sv
// Directed testbench for io_port. Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point, away from the active edge.
module tb_io_port;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        CLK;
  logic        RST;
  logic [15:0] ADDR;
  logic [15:0] DATA_IN;
  logic        WR;
  logic        RD;
  logic [15:0] DATA_OUT;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;

  int errors = 0;
  int checks = 0;

  io_port #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ADDR      (ADDR),
    .DATA_IN   (DATA_IN),
    .WR        (WR),
    .RD        (RD),
    .DATA_OUT  (DATA_OUT),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; DATA_IN = d; WR = 1'b1;
    tick();
    WR = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    ADDR = a; RD = 1'b1;
    tick();
    RD = 1'b0;
  endtask

  initial begin
    RST = 1'b0; ADDR = 16'h0000; DATA_IN = 16'h0000; WR = 1'b0; RD = 1'b0;
    OUT_READY = 1'b0; IN_DATA = 16'h0000; IN_VALID = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_data_out", DATA_OUT, 16'h0000);
    check("rst_out_valid", {15'd0, OUT_VALID}, 16'h0000);
    check("rst_in_ready", {15'd0, IN_READY}, 16'h0001);
    RST = 1'b1;

    // Status after reset, then DATA_OUT returns to zero
    bus_rd(BASE + 16'd1);
    check("stat_after_rst", DATA_OUT, 16'h0001);
    tick();
    check("data_out_idle", DATA_OUT, 16'h0000);

    // Fill to full with the consumer stalled, then overflow
    for (int i = 0; i < 8; i++) bus_wr(BASE, 16'd100 + 16'(i));
    check("head_when_full", OUT_DATA, 16'd100);
    bus_rd(BASE + 16'd1);
    check("stat_full", DATA_OUT, 16'h0082);
    bus_wr(BASE, 16'd108);
    bus_rd(BASE + 16'd1);
    check("stat_full_ovf", DATA_OUT, 16'h008A);

    // Drain one word per cycle
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {15'd0, OUT_VALID}, 16'h0001);
      check("drain_data", OUT_DATA, 16'd100 + 16'(i));
      tick();
    end
    check("drain_empty", {15'd0, OUT_VALID}, 16'h0000);
    OUT_READY = 1'b0;

    // Clear overflow, refill, then push on the same edge as a pop
    bus_wr(BASE + 16'd2, 16'h0002);
    for (int i = 0; i < 8; i++) bus_wr(BASE, 16'd110 + 16'(i));
    OUT_READY = 1'b1;
    bus_wr(BASE, 16'd200);
    OUT_READY = 1'b0;
    check("push_pop_head", OUT_DATA, 16'd111);
    bus_rd(BASE + 16'd1);
    check("push_pop_stat", DATA_OUT, 16'h0082);
    OUT_READY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("drain2_data", OUT_DATA, 16'd111 + 16'(i));
      tick();
    end
    check("last_is_200", OUT_DATA, 16'd200);
    tick();
    check("drain2_empty", {15'd0, OUT_VALID}, 16'h0000);
    OUT_READY = 1'b0;

    // Status read on the same edge as a pop reports the pre-edge count
    bus_wr(BASE, 16'd300);
    check("one_word_head", OUT_DATA, 16'd300);
    OUT_READY = 1'b1;
    bus_rd(BASE + 16'd1);
    OUT_READY = 1'b0;
    check("stat_pre_edge", DATA_OUT, 16'h0010);
    check("popped_empty", {15'd0, OUT_VALID}, 16'h0000);

    // RX capture and reads
    IN_DATA = 16'd26; IN_VALID = 1'b1;
    tick();
    check("rx_in_ready_low", {15'd0, IN_READY}, 16'h0000);
    IN_DATA = 16'd99;
    tick();
    IN_VALID = 1'b0;
    bus_rd(BASE + 16'd1);
    check("stat_rx_full", DATA_OUT, 16'h0005);
    bus_rd(BASE);
    check("rx_read1", DATA_OUT, 16'd26);
    check("rx_in_ready_back", {15'd0, IN_READY}, 16'h0001);
    bus_rd(BASE);
    check("rx_read2", DATA_OUT, 16'd26);
    check("rx_read2_ready", {15'd0, IN_READY}, 16'h0001);

    // WR and RD together: write done, read ignored
    ADDR = BASE; DATA_IN = 16'h0055; WR = 1'b1; RD = 1'b1;
    tick();
    WR = 1'b0; RD = 1'b0;
    check("wr_rd_data_out", DATA_OUT, 16'h0000);
    check("wr_rd_pushed", OUT_DATA, 16'h0055);

    // Reach 5 queued with overflow set, then flush and clear
    for (int i = 0; i < 7; i++) bus_wr(BASE, 16'h0060 + 16'(i));
    bus_wr(BASE, 16'h0070);
    OUT_READY = 1'b1;
    tick(); tick(); tick();
    OUT_READY = 1'b0;
    check("head_after_3pops", OUT_DATA, 16'h0062);
    bus_rd(BASE + 16'd1);
    check("stat_5_ovf", DATA_OUT, 16'h0058);
    bus_wr(BASE + 16'd2, 16'h0003);
    bus_rd(BASE + 16'd1);
    check("stat_flushed", DATA_OUT, 16'h0001);
    check("flushed_invalid", {15'd0, OUT_VALID}, 16'h0000);

    // Asynchronous reset mid-stream
    bus_wr(BASE, 16'h0011);
    bus_wr(BASE, 16'h0022);
    IN_DATA = 16'h0077; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    bus_rd(BASE + 16'd1);
    check("pre_rst_stat", DATA_OUT, 16'h0024);
    #1 RST = 1'b0;
    #1;
    check("async_data_out", DATA_OUT, 16'h0000);
    check("async_out_valid", {15'd0, OUT_VALID}, 16'h0000);
    check("async_in_ready", {15'd0, IN_READY}, 16'h0001);
    tick();
    RST = 1'b1;
    bus_rd(BASE);
    check("rx_word_reset", DATA_OUT, 16'h0000);
    bus_rd(BASE + 16'd1);
    check("stat_after_rst2", DATA_OUT, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
